// File: rtl/ysyx_22041207_axi_pkg.sv
// Shared types and AXI encodings for the IF-side AXI4 read bridge.
package ysyx_22041207_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22041207_axi_rd_bridge.sv
// Single-outstanding AXI4 read bridge between IF and memory; always fetches one aligned doubleword.
// Optional watchdog on the AR/R wait states is enabled with `define AXI_RD_TIMEOUT_EN.
module ysyx_22041207_axi_rd_bridge
  import ysyx_22041207_axi_pkg::*;
#(
  parameter int          ADDR_W         = 64,
  parameter logic [3:0]  ID_VAL         = 4'd0,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic [7:0]        r_size_i,

  output logic [63:0]       data_read_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              err_o,

  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,

  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);

  rd_state_e         state, state_nxt;
  logic              r_ready_nxt, arvalid_nxt, rready_nxt, data_valid_nxt, err_nxt;
  logic [63:0]       data_read_nxt;
  logic [ADDR_W-1:0] araddr_nxt, data_addr_nxt;
  logic              timeout;
  logic              beat_err;

  assign arid    = ID_VAL;
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_8B;
  assign arburst = AXI_BURST_INCR;

  assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != ID_VAL);

`ifdef AXI_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             unused;

  assign unused  = ^r_size_i;
  assign timeout = ((state == ST_AR) || (state == ST_R)) &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change so AR and R each get a full budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if ((state == ST_AR) || (state == ST_R)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused;

  assign unused  = (^r_size_i) ^ (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_nxt      = state;
    r_ready_nxt    = r_ready_o;
    arvalid_nxt    = arvalid;
    rready_nxt     = rready;
    data_valid_nxt = data_valid_o;
    err_nxt        = err_o;
    data_read_nxt  = data_read_o;
    araddr_nxt     = araddr;
    data_addr_nxt  = data_addr_o;

    case (state)
      ST_IDLE: begin
        // r_ready_o low in IDLE marks a latched request waiting to launch on AR.
        if (r_ready_o) begin
          if (r_valid_i) begin
            data_addr_nxt = r_addr_i;
            araddr_nxt    = {r_addr_i[ADDR_W-1:3], 3'b000};
            r_ready_nxt   = 1'b0;
          end
        end else begin
          arvalid_nxt = 1'b1;
          state_nxt   = ST_AR;
        end
      end

      ST_AR: begin
        if (arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = ST_R;
        end else if (timeout) begin
          arvalid_nxt    = 1'b0;
          data_read_nxt  = '0;
          err_nxt        = 1'b1;
          data_valid_nxt = 1'b1;
          state_nxt      = ST_DONE;
        end
      end

      ST_R: begin
        if (rvalid && rlast) begin
          data_read_nxt  = rdata;
          err_nxt        = err_o || beat_err;
          rready_nxt     = 1'b0;
          data_valid_nxt = 1'b1;
          state_nxt      = ST_DONE;
        end else begin
          // A non-last beat is swallowed but poisons the result.
          if (rvalid) err_nxt = 1'b1;
          if (timeout) begin
            rready_nxt     = 1'b0;
            data_read_nxt  = '0;
            err_nxt        = 1'b1;
            data_valid_nxt = 1'b1;
            state_nxt      = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (data_ready_i) begin
          data_valid_nxt = 1'b0;
          err_nxt        = 1'b0;
          r_ready_nxt    = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state        <= ST_IDLE;
      r_ready_o    <= 1'b1;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      data_valid_o <= 1'b0;
      err_o        <= 1'b0;
      data_read_o  <= '0;
      araddr       <= '0;
      data_addr_o  <= '0;
    end else begin
      state        <= state_nxt;
      r_ready_o    <= r_ready_nxt;
      arvalid      <= arvalid_nxt;
      rready       <= rready_nxt;
      data_valid_o <= data_valid_nxt;
      err_o        <= err_nxt;
      data_read_o  <= data_read_nxt;
      araddr       <= araddr_nxt;
      data_addr_o  <= data_addr_nxt;
    end
  end

endmodule

// File: doc/ysyx_22041207_axi_rd_bridge.md
Name: ysyx_22041207_axi_rd_bridge

Overview:
- Sits directly upstream of the IF stage.
- Accepts IF's single-beat read requests on the simple rx handshake: an address handshake, then a data handshake.
- Turns each request into one AXI4 read transaction (AR/R channels) toward the memory/crossbar.
- Always returns the full aligned 64-bit doubleword. IF selects the 32-bit half using address bit 2.

Parameters:
- ADDR_W, 64, width of request and AXI addresses
- ID_VAL, 0, constant driven on arid; also the only rid accepted
- TIMEOUT_CYCLES, 1023, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- r_valid_i  in  1  IF request valid
- r_ready_o  out  1  bridge can accept a request
- r_addr_i  in  ADDR_W  request byte address
- r_size_i  in  8  byte mask; accepted for compatibility, always fetches 8 bytes
- data_read_o  out  64  returned doubleword
- data_addr_o  out  ADDR_W  unaligned request address echoed with data
- data_valid_o  out  1  returned data valid
- data_ready_i  in  1  IF accepts data
- err_o  out  1  qualified by data_valid_o; transaction returned an error
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  ADDR_W  AXI AR address
- arid  out  4  AXI AR ID
- arlen  out  8  AXI AR burst length
- arsize  out  3  AXI AR transfer size
- arburst  out  2  AXI AR burst type
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  64  AXI R data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last beat
- rid  in  4  AXI R ID

Behaviour:
- Constant outputs: arlen=0, arsize=3'b011, arburst=2'b01 (INCR), arid=ID_VAL.
- FSM states: IDLE, AR, R, DONE.
- Reset (sync, rst=1 at posedge): state=IDLE; r_ready_o=1; arvalid=0; rready=0; data_valid_o=0; err_o=0; data_read_o=0; araddr=0; data_addr_o=0.
- IDLE:
  - r_ready_o=1.
  - On r_valid_i&&r_ready_o: latch data_addr_o=r_addr_i and araddr={r_addr_i[ADDR_W-1:3],3'b0}.
  - Next cycle: r_ready_o=0, arvalid=1, state=AR.
- AR:
  - arvalid and araddr are held stable until arready.
  - On arvalid&&arready: arvalid=0, rready=1, state=R.
- R:
  - On rvalid&&rready&&rlast: capture rdata into data_read_o; err_o=(rresp!=2'b00)||(rid!=ID_VAL).
  - Same edge: rready=0, data_valid_o=1, state=DONE.
  - A beat with rlast=0 is a protocol error: it is consumed, err_o is sticky-set, and the bridge keeps waiting for rlast.
- DONE:
  - data_valid_o, data_read_o, data_addr_o and err_o are held stable until data_ready_i.
  - On data_valid_o&&data_ready_i: data_valid_o=0, err_o=0, r_ready_o=1, state=IDLE.
  - data_ready_i high before data_valid_o is legal; IF raises it early. The handshake then completes in the first DONE cycle.
- Latency:
  - Minimum 4 cycles from request accept to data_valid_o, with arready and rvalid high immediately.
  - Each AXI wait cycle adds one cycle.
- One outstanding transaction, no pipelining. A new request is accepted no earlier than the cycle after the data handshake.
- No cancel. A redirect in IF does not abort an in-flight read; IF discards stale data by comparing data_addr_o against its pc.
- Simultaneous events: rst dominates every transition. Reset mid-AR/R drops arvalid/rready immediately; this is legal only at system reset.
- Data path is 64 bits; no sign/width conversion.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to AR and R and increments each cycle spent in AR or R.
  - Reaching TIMEOUT_CYCLES forces state=DONE with data_read_o=0 and err_o=1.
  - arvalid and rready drop in the same cycle.
- Without the macro: no counter is present, and the bridge waits indefinitely in AR or R.

Decomposition:
- Package ysyx_22041207_axi_pkg holds:
  - the FSM state enum;
  - AXI_BURST_INCR=2'b01;
  - AXI_SIZE_8B=3'b011;
  - AXI_RESP_OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- No sub-module; the single FSM plus the optional counter is inline.

Test Plan:
- Zero-wait read, addr 0x80000004, rdata 0x00000013_00100093 -> araddr 0x80000000; data_valid_o 4 cycles after accept; data_read_o as given; data_addr_o 0x80000004; err_o=0.
- arready delayed 3 cycles and rvalid delayed 5 cycles -> arvalid and araddr stable throughout; data_valid_o at cycle 12 after accept.
- rresp=2'b10 with rdata=0xDEADBEEF -> data_valid_o=1, err_o=1, data_read_o=0xDEADBEEF; err_o cleared after the handshake.
- data_ready_i held low 6 cycles in DONE -> outputs stable and r_ready_o=0 throughout; a new r_valid_i is not accepted until the cycle after data_ready_i=1.
- rst asserted mid-R -> next cycle: state IDLE, rready=0, r_ready_o=1, data_valid_o=0; the following request completes normally.
- With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES=8, rvalid never asserted -> data_valid_o=1, err_o=1, data_read_o=0 after 8 cycles in R; rready=0.
